pipeline_debug_unit: RTL and testbench

//  Debug controller for the 5-stage MIPS pipeline: gates the pipeline enable (run/step/halt/breakpoint),

---
 rtl/pipeline_debug_unit_pkg.sv | 30 +++
 rtl/pipeline_debug_unit_snapshot_ram.sv | 28 ++
 rtl/pipeline_debug_unit.sv | 217 +++++++++++++++++++++
 tb/tb_pipeline_debug_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_debug_unit_pkg.sv
// Shared definitions for the pipeline debug unit: command bytes, dump header
// byte, controller states and a byte-count helper.
package pipeline_debug_unit_pkg;

  localparam logic [7:0] CMD_RUN    = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP   = 8'h53;  // 'S'
  localparam logic [7:0] CMD_HALT   = 8'h48;  // 'H'
  localparam logic [7:0] CMD_DUMP   = 8'h44;  // 'D'
  localparam logic [7:0] CMD_CLEAR  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_SET_BP = 8'h42;  // 'B' followed by lo, hi bytes
  localparam logic [7:0] CMD_CLR_BP = 8'h62;  // 'b'
  localparam logic [7:0] DUMP_HDR   = 8'hA5;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_RUN,
    ST_STEP,
    ST_BP_LO,
    ST_BP_HI,
    ST_D_HDR,
    ST_D_CNT,
    ST_D_DATA
  } dbg_state_e;

  // Number of UART bytes needed to carry a snapshot of the given width.
  function automatic int num_bytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/pipeline_debug_unit_snapshot_ram.sv
// Snapshot store: DEPTH entries of the captured debug bus, synchronous write,
// asynchronous read so the dump byte mux sees the entry in the same cycle.
module pipeline_debug_unit_snapshot_ram
  import pipeline_debug_unit_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DBG_WIDTH = 322
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
  input  logic [DBG_WIDTH-1:0]       wr_data_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
  output logic [DBG_WIDTH-1:0]       rd_data_o
);

  logic [DBG_WIDTH-1:0] mem_q [DEPTH];

  // Write one snapshot on each capture edge; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pipeline_debug_unit.sv
// Debug controller for the 5-stage pipeline: gates the core enable
// (run/step/halt/breakpoint), records the pipeline-latch bus into a circular
// snapshot buffer, and streams snapshots to the UART on request.
// Handshakes: a command byte is consumed on a rising edge where
// cmd_valid && cmd_rd; a tx byte is written on a rising edge where tx_wr,
// and tx_wr is only raised while tx_full is low.
module pipeline_debug_unit
  import pipeline_debug_unit_pkg::*;
#(
  parameter int DBG_WIDTH = 322,
  parameter int DEPTH     = 4,
  parameter int PC_WIDTH  = 10
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  input  logic [7:0]                 cmd_data,
  output logic                       cmd_rd,
  input  logic [DBG_WIDTH-1:0]       debug_signal,
  input  logic [PC_WIDTH-1:0]        pc_in,
  output logic                       cpu_enable,
  output logic [7:0]                 tx_data,
  output logic                       tx_wr,
  input  logic                       tx_full,
  output logic                       halted,
  output logic [$clog2(DEPTH):0]     snap_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NB = num_bytes(DBG_WIDTH);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  dbg_state_e            state_q, state_d;
  logic                  cap_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  bp_en_q, bp_en_d;
  logic [PC_WIDTH-1:0]   bp_addr_q, bp_addr_d;
  logic [7:0]            bp_lo_q, bp_lo_d;
  logic [CW-1:0]         ent_q, ent_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic                  clear_snaps;
  logic                  bp_hit;
  logic [AW-1:0]         rd_ptr;
  logic [DBG_WIDTH-1:0]  rd_entry;
  logic [NB*8-1:0]       entry_pad;
  logic [7:0]            data_byte;

  pipeline_debug_unit_snapshot_ram #(
    .DEPTH     (DEPTH),
    .DBG_WIDTH (DBG_WIDTH)
  ) u_snapshot_ram (
    .clk_i     (clock),
    .we_i      (cap_q),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (debug_signal),
    .rd_addr_i (rd_ptr),
    .rd_data_o (rd_entry)
  );

  // Oldest valid entry sits snap_count slots behind the write pointer.
  assign rd_ptr     = wr_ptr_q - cnt_q[AW-1:0] + ent_q[AW-1:0];
  assign bp_hit     = bp_en_q && (pc_in == bp_addr_q);
  assign halted     = (state_q == ST_HALT);
  assign snap_count = cnt_q;

  // Zero-pad the entry to whole bytes and select the current byte.
  always_comb begin
    entry_pad                 = '0;
    entry_pad[DBG_WIDTH-1:0]  = rd_entry;
    data_byte                 = entry_pad[{byte_q, 3'b000} +: 8];
  end

  // Next state, command pops, enable gating and dump byte stream.
  always_comb begin
    state_d     = state_q;
    bp_en_d     = bp_en_q;
    bp_addr_d   = bp_addr_q;
    bp_lo_d     = bp_lo_q;
    ent_d       = ent_q;
    byte_d      = byte_q;
    clear_snaps = 1'b0;
    cmd_rd      = 1'b0;
    cpu_enable  = 1'b0;
    tx_wr       = 1'b0;
    tx_data     = 8'h00;
    unique case (state_q)
      ST_HALT: begin
        cmd_rd = cmd_valid;
        if (cmd_valid) begin
          unique case (cmd_data)
            CMD_RUN:    state_d = ST_RUN;
            CMD_STEP:   state_d = ST_STEP;
            CMD_DUMP: begin
              state_d = ST_D_HDR;
              ent_d   = '0;
              byte_d  = '0;
            end
            CMD_CLEAR:  clear_snaps = 1'b1;
            CMD_SET_BP: state_d = ST_BP_LO;
            CMD_CLR_BP: bp_en_d = 1'b0;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cpu_enable = !bp_hit;
        cmd_rd     = cmd_valid;
        if (bp_hit) begin
          state_d = ST_HALT;
        end
        if (cmd_valid) begin
          unique case (cmd_data)
            CMD_HALT:   state_d = ST_HALT;
            CMD_CLEAR:  clear_snaps = 1'b1;
            CMD_CLR_BP: bp_en_d = 1'b0;
            default: ;
          endcase
        end
      end
      ST_STEP: begin
        cpu_enable = 1'b1;
        state_d    = ST_HALT;
      end
      ST_BP_LO: begin
        cmd_rd = cmd_valid;
        if (cmd_valid) begin
          bp_lo_d = cmd_data;
          state_d = ST_BP_HI;
        end
      end
      ST_BP_HI: begin
        cmd_rd = cmd_valid;
        if (cmd_valid) begin
          bp_addr_d = PC_WIDTH'({cmd_data, bp_lo_q});
          bp_en_d   = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_D_HDR: begin
        tx_data = DUMP_HDR;
        if (!tx_full) begin
          tx_wr   = 1'b1;
          state_d = ST_D_CNT;
        end
      end
      ST_D_CNT: begin
        tx_data = 8'(cnt_q);
        if (!tx_full) begin
          tx_wr   = 1'b1;
          state_d = (cnt_q == '0) ? ST_HALT : ST_D_DATA;
        end
      end
      ST_D_DATA: begin
        tx_data = data_byte;
        if (!tx_full) begin
          tx_wr = 1'b1;
          if (byte_q == LAST_BYTE) begin
            byte_d = '0;
            if (ent_q == cnt_q - CW'(1)) begin
              state_d = ST_HALT;
            end else begin
              ent_d = ent_q + CW'(1);
            end
          end else begin
            byte_d = byte_q + BW'(1);
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Controller state, breakpoint and dump counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_HALT;
      bp_en_q   <= 1'b0;
      bp_addr_q <= '0;
      bp_lo_q   <= '0;
      ent_q     <= '0;
      byte_q    <= '0;
    end else begin
      state_q   <= state_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
      bp_lo_q   <= bp_lo_d;
      ent_q     <= ent_d;
      byte_q    <= byte_d;
    end
  end

  // Capture one cycle after each enabled cycle so the snapshot holds the
  // latch contents that the enabled edge produced.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_q    <= 1'b0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cap_q <= cpu_enable;
      if (clear_snaps) begin
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else if (cap_q) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (cnt_q != DEPTH_C) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_debug_unit.sv
// Bench for pipeline_debug_unit: random debug bus and tx back-pressure,
// a snapshot-queue reference model, and expected dump byte streams.
module tb_pipeline_debug_unit;

  localparam int DBG_WIDTH = 322;
  localparam int DEPTH     = 4;
  localparam int PC_WIDTH  = 10;
  localparam int NB        = (DBG_WIDTH + 7) / 8;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic                  clock;
  logic                  reset_n;
  logic                  cmd_valid;
  logic [7:0]            cmd_data;
  logic                  cmd_rd;
  logic [DBG_WIDTH-1:0]  debug_signal;
  logic [PC_WIDTH-1:0]   pc_in;
  logic                  cpu_enable;
  logic [7:0]            tx_data;
  logic                  tx_wr;
  logic                  tx_full;
  logic                  halted;
  logic [CW-1:0]         snap_count;

  pipeline_debug_unit #(
    .DBG_WIDTH (DBG_WIDTH),
    .DEPTH     (DEPTH),
    .PC_WIDTH  (PC_WIDTH)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_rd       (cmd_rd),
    .debug_signal (debug_signal),
    .pc_in        (pc_in),
    .cpu_enable   (cpu_enable),
    .tx_data      (tx_data),
    .tx_wr        (tx_wr),
    .tx_full      (tx_full),
    .halted       (halted),
    .snap_count   (snap_count)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;

  bit                    mon_on;
  bit                    in_dump;
  bit                    m_run;
  bit                    m_step;
  bit                    hit_pend;
  bit                    m_bp_en;
  int                    m_bp_phase;
  logic [7:0]            m_bp_lo;
  logic [PC_WIDTH-1:0]   m_bp_addr;
  logic [PC_WIDTH-1:0]   pc_val;
  bit                    en_last;
  bit                    mon_hit;
  bit                    mon_exp_en;
  logic [351:0]          rnd_word;
  logic [DBG_WIDTH-1:0]  snaps[$];
  logic [7:0]            exp_q[$];
  int                    rounds_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the effect of a consumed command byte to the model.
  task automatic apply_model(input logic [7:0] b);
    if (m_bp_phase == 1) begin
      m_bp_lo    = b;
      m_bp_phase = 2;
    end else if (m_bp_phase == 2) begin
      m_bp_addr  = PC_WIDTH'({b, m_bp_lo});
      m_bp_en    = 1'b1;
      m_bp_phase = 0;
    end else if (!m_run) begin
      case (b)
        8'h52: m_run = 1'b1;
        8'h53: m_step = 1'b1;
        8'h43: snaps.delete();
        8'h42: m_bp_phase = 1;
        8'h62: m_bp_en = 1'b0;
        default: ;
      endcase
    end else begin
      case (b)
        8'h48: m_run = 1'b0;
        8'h43: snaps.delete();
        8'h62: m_bp_en = 1'b0;
        default: ;
      endcase
    end
  endtask

  // Per-cycle driver and model: new debug bus and PC every cycle, record a
  // snapshot for the cycle following each enabled cycle, check cpu_enable.
  always @(negedge clock) begin
    if (mon_on) begin
      if (hit_pend) begin
        m_run    = 1'b0;
        hit_pend = 1'b0;
      end
      if (en_last) pc_val = pc_val + 1'b1;
      for (int k = 0; k < 11; k++) rnd_word[k*32 +: 32] = $urandom;
      debug_signal = rnd_word[DBG_WIDTH-1:0];
      pc_in        = pc_val;
      if (en_last) begin
        snaps.push_back(debug_signal);
        if (snaps.size() > DEPTH) void'(snaps.pop_front());
      end
      mon_hit    = m_bp_en && (pc_val == m_bp_addr);
      mon_exp_en = m_step || (m_run && !mon_hit);
      if (m_run && mon_hit) hit_pend = 1'b1;
      m_step  = 1'b0;
      en_last = mon_exp_en;
      #1;
      check("cpu_enable", {31'b0, cpu_enable}, {31'b0, mon_exp_en});
      if (!in_dump) check("tx_idle", {31'b0, tx_wr}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_data  = b;
    #2;
    while (!cmd_rd && n < 50) begin
      @(negedge clock);
      #2;
      n++;
    end
    check("cmd_rd", {31'b0, cmd_rd}, 32'd1);
    if (cmd_rd) begin
      @(posedge clock);
      apply_model(b);
    end
    #1;
    cmd_valid = 1'b0;
  endtask

  // Issue 'D' and collect the byte stream. stall_at>=0 holds tx_full high for
  // 20 cycles once that many bytes were received; abort_at>=0 returns early.
  task automatic run_dump(input int stall_at, input int abort_at);
    logic [7:0]      got[$];
    logic [NB*8-1:0] pad;
    int              cyc;
    int              stall_left;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(snaps.size()));
    foreach (snaps[i]) begin
      pad = '0;
      pad[DBG_WIDTH-1:0] = snaps[i];
      for (int j = 0; j < NB; j++) exp_q.push_back(pad[j*8 +: 8]);
    end
    send_cmd(8'h44);
    in_dump    = 1'b1;
    cyc        = 0;
    stall_left = 20;
    while (got.size() < exp_q.size() && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (stall_at >= 0 && got.size() == stall_at && stall_left > 0) begin
        tx_full = 1'b1;
        stall_left--;
        #1;
        check("stall_no_wr", {31'b0, tx_wr}, 32'd0);
        check("stall_byte_held", {24'b0, tx_data}, {24'b0, exp_q[stall_at]});
        continue;
      end
      tx_full = ($urandom_range(0, 3) == 0);
      #1;
      if (tx_full) check("wr_when_full", {31'b0, tx_wr}, 32'd0);
      if (tx_wr) got.push_back(tx_data);
      if (abort_at >= 0 && got.size() == abort_at) break;
    end
    if (abort_at >= 0) begin
      check("dump_reached_abort", got.size(), abort_at);
      return;
    end
    in_dump = 1'b0;
    check("dump_len", got.size(), exp_q.size());
    foreach (got[i]) begin
      if (i < exp_q.size())
        check($sformatf("dump_byte[%0d]", i), {24'b0, got[i]}, {24'b0, exp_q[i]});
    end
    @(negedge clock);
    tx_full = 1'b0;
    #1;
    check("dump_end_halted", {31'b0, halted}, 32'd1);
    check("dump_keeps_count", {29'b0, snap_count}, snaps.size());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_data     = 8'h00;
    tx_full      = 1'b0;
    debug_signal = '0;
    pc_in        = '0;
    pc_val       = '0;
    mon_on       = 1'b0;
    in_dump      = 1'b0;
    m_run        = 1'b0;
    m_step       = 1'b0;
    hit_pend     = 1'b0;
    m_bp_en      = 1'b0;
    m_bp_phase   = 0;
    m_bp_lo      = '0;
    m_bp_addr    = '0;
    en_last      = 1'b0;

    repeat (3) @(negedge clock);
    #1;
    check("rst_cpu_enable", {31'b0, cpu_enable}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd1);
    check("rst_snap_count", {29'b0, snap_count}, 32'd0);
    check("rst_tx_wr", {31'b0, tx_wr}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_cmd_rd", {31'b0, cmd_rd}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    mon_on  = 1'b1;

    // idle after reset
    repeat (10) @(negedge clock);
    #1;
    check("idle_halted", {31'b0, halted}, 32'd1);
    check("idle_snap_count", {29'b0, snap_count}, 32'd0);

    // single step then dump
    send_cmd(8'h53);
    repeat (4) @(negedge clock);
    #1;
    check("step_snap_count", {29'b0, snap_count}, 32'd1);
    run_dump(-1, -1);

    // free run then halt: buffer wraps
    send_cmd(8'h52);
    repeat (6) @(negedge clock);
    send_cmd(8'h48);
    repeat (3) @(negedge clock);
    #1;
    check("run_snap_count", {29'b0, snap_count}, 32'd4);
    check("run_halted", {31'b0, halted}, 32'd1);
    run_dump(-1, -1);

    // unknown byte is discarded; clear empties the buffer
    send_cmd(8'h7E);
    @(negedge clock);
    #1;
    check("unknown_halted", {31'b0, halted}, 32'd1);
    check("unknown_count", {29'b0, snap_count}, 32'd4);
    send_cmd(8'h43);
    @(negedge clock);
    #1;
    check("clear_count", {29'b0, snap_count}, 32'd0);
    run_dump(-1, -1);

    // random run/step rounds
    for (int r = 0; r < 4; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        rounds_n = $urandom_range(1, 5);
        for (int s = 0; s < rounds_n; s++) begin
          send_cmd(8'h53);
          repeat (2) @(negedge clock);
        end
      end else begin
        send_cmd(8'h52);
        repeat ($urandom_range(1, 8)) @(negedge clock);
        send_cmd(8'h48);
      end
      repeat (3) @(negedge clock);
      #1;
      check("rand_snap_count", {29'b0, snap_count}, snaps.size());
      run_dump(-1, -1);
    end

    // breakpoint at 0x010 with PC counting from 0x00C
    send_cmd(8'h43);
    pc_val = 10'h00C;
    send_cmd(8'h42);
    send_cmd(8'h10);
    send_cmd(8'h00);
    send_cmd(8'h52);
    for (int w = 0; w < 30; w++) begin
      @(negedge clock);
      #2;
      if (halted) break;
    end
    check("bp_halted", {31'b0, halted}, 32'd1);
    check("bp_pc", {22'b0, pc_in}, 32'h010);
    repeat (2) @(negedge clock);
    #1;
    check("bp_snap_count", {29'b0, snap_count}, 32'd4);
    // step executes at the breakpoint address
    send_cmd(8'h53);
    repeat (3) @(negedge clock);
    #1;
    check("bp_step_pc", {22'b0, pc_in}, 32'h011);
    send_cmd(8'h62);
    send_cmd(8'h52);
    repeat (5) @(negedge clock);
    send_cmd(8'h48);
    repeat (3) @(negedge clock);

    // back-pressure in the data phase
    run_dump(5, -1);

    // reset in the middle of a dump
    run_dump(-1, 10);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cpu_enable", {31'b0, cpu_enable}, 32'd0);
    check("mid_rst_halted", {31'b0, halted}, 32'd1);
    check("mid_rst_tx_wr", {31'b0, tx_wr}, 32'd0);
    check("mid_rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("mid_rst_snap_count", {29'b0, snap_count}, 32'd0);
    check("mid_rst_cmd_rd", {31'b0, cmd_rd}, 32'd0);
    snaps.delete();
    m_run      = 1'b0;
    m_step     = 1'b0;
    hit_pend   = 1'b0;
    m_bp_en    = 1'b0;
    m_bp_phase = 0;
    en_last    = 1'b0;
    in_dump    = 1'b0;
    tx_full    = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    run_dump(-1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
